// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops in EXEC, shift-add MUL and restoring-division MOD in ITER.
// Optional macro ALU_DIV_EN adds opcode 1010 = DIV (quotient from the same divider).
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [3:0]       Control,
  input  logic             enable,
  output logic [WIDTH-1:0] C_bus,
  output logic             Z_flag,
  output logic             busy,
  output logic             done
);
  // state  | meaning
  // IDLE   | waiting for enable; operands latched on accept
  // EXEC   | single-cycle op, result written on next edge
  // ITER   | one operand bit per edge, WIDTH edges
  // FINISH | iterative result written, done pulsed
  typedef enum logic [1:0] {IDLE, EXEC, ITER, FINISH} state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_MOD   = 4'b0100;
  localparam logic [3:0] OP_PASSA = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_INC   = 4'b0111;
  localparam logic [3:0] OP_DEC   = 4'b1000;
  localparam logic [3:0] OP_RST   = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reg_a, reg_b, acc, result, rem_sub;
  logic [WIDTH:0]   rem_sh;
  logic [3:0]       op;
  logic [CNT_W-1:0] cnt;
  logic             iter_op, write_en, res_valid, rem_ge, quo_bit;

  always_comb begin
    iter_op = 1'b0;
    case (Control)
      OP_MUL, OP_MOD: iter_op = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV:         iter_op = 1'b1;
`endif
      default:        iter_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = iter_op ? ITER : EXEC;
      EXEC:    state_nxt = IDLE;
      ITER:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign write_en = (state == EXEC) || (state == FINISH);

  // Restoring divider step: acc holds the partial remainder, reg_a shifts the dividend out MSB-first.
  assign rem_sh  = {acc, reg_a[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, reg_b});
  assign rem_sub = rem_sh[WIDTH-1:0] - reg_b;
`ifdef ALU_DIV_EN
  assign quo_bit = rem_ge;
`else
  assign quo_bit = 1'b0;
`endif

  always_comb begin
    result    = '0;
    res_valid = 1'b1;
    case (op)
      OP_ADD:         result = reg_a + reg_b;
      OP_SUB:         result = reg_a - reg_b;
      OP_MUL, OP_MOD: result = acc;
      OP_PASSA:       result = reg_a;
      OP_PASSB:       result = reg_b;
      OP_INC:         result = reg_a + WIDTH'(1);
      OP_DEC:         result = reg_a - WIDTH'(1);
      OP_RST:         result = '0;
`ifdef ALU_DIV_EN
      OP_DIV:         result = reg_a;
`endif
      default:        res_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      C_bus  <= '0;
      Z_flag <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      op     <= '0;
    end else begin
      done <= write_en;
      case (state)
        IDLE: if (enable) begin
          reg_a <= A_bus;
          reg_b <= B_bus;
          op    <= Control;
          acc   <= '0;
          cnt   <= '0;
        end
        ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (op == OP_MUL) begin
            if (reg_b[0]) acc <= acc + reg_a;
            reg_a <= reg_a << 1;
            reg_b <= reg_b >> 1;
          end else begin
            acc   <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            reg_a <= {reg_a[WIDTH-2:0], quo_bit};
          end
        end
        default: if (write_en && res_valid) begin
          C_bus  <= result;
          Z_flag <= (result == '0);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32); honours ALU_DIV_EN.
module tb_alu_multicycle;
  logic        clk = 0, rst = 1, enable = 0;
  logic [31:0] A_bus = 0, B_bus = 0, C_bus;
  logic [3:0]  Control = 0;
  logic        Z_flag, busy, done;
  int          tests_run = 0, tests_failed = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A_bus(A_bus), .B_bus(B_bus), .Control(Control),
    .enable(enable), .C_bus(C_bus), .Z_flag(Z_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Control = op; A_bus = a; B_bus = b; enable = 1;
    tick();
    enable = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_c,
                        input logic exp_z);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (C_bus !== exp_c) begin
      tests_failed++;
      $display("FAIL %s C_bus: got %h expected %h", name, C_bus, exp_c);
    end
    tests_run++;
    if (Z_flag !== exp_z) begin
      tests_failed++;
      $display("FAIL %s Z_flag: got %b expected %b", name, Z_flag, exp_z);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    tests_run++;
    if ({C_bus, Z_flag, busy, done} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset: got C=%h Z=%b busy=%b done=%b expected all zero", C_bus, Z_flag, busy, done);
    end
  endtask

  task automatic test_add_back_to_back();
    int lat;
    run_op("add", 4'b0001, 32'd5, 32'd7, 1, 32'd12, 1'b0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL add busy in done cycle: got %b expected 0", busy);
    end
    issue(4'b0010, 32'd9, 32'd9);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    wait_done(lat);
    tests_run++;
    if (lat !== 1 || C_bus !== 32'd0 || Z_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b sub: got lat=%0d C=%h Z=%b expected lat=1 C=0 Z=1", lat, C_bus, Z_flag);
    end
  endtask

  task automatic test_mul();
    int lat, busy_cycles;
    issue(4'b0011, 32'd1234, 32'd5678);
    A_bus = 32'hDEAD_BEEF; B_bus = 32'h1234_5678;
    busy_cycles = busy ? 1 : 0;
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (done) break;
      if (busy) busy_cycles++;
    end
    tests_run++;
    if (lat !== 33 || busy_cycles !== 33) begin
      tests_failed++;
      $display("FAIL mul timing: got lat=%0d busy=%0d expected 33/33", lat, busy_cycles);
    end
    tests_run++;
    if (C_bus !== 32'd7006652 || Z_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul result: got %h Z=%b expected %h Z=0", C_bus, Z_flag, 32'd7006652);
    end
    run_op("mul_wrap", 4'b0011, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_mod();
    run_op("mod_100_7", 4'b0100, 32'd100, 32'd7, 33, 32'd2, 1'b0);
    run_op("mod_by_0", 4'b0100, 32'd100, 32'd0, 33, 32'd100, 1'b0);
    run_op("mod_21_7", 4'b0100, 32'd21, 32'd7, 33, 32'd0, 1'b1);
  endtask

  task automatic test_wrap_pass();
    run_op("dec_wrap", 4'b1000, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("inc_wrap", 4'b0111, 32'hFFFF_FFFF, 32'd0, 1, 32'd0, 1'b1);
    run_op("sub_wrap", 4'b0010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 1'b0);
    run_op("pass_a", 4'b0101, 32'h55, 32'h99, 1, 32'h55, 1'b0);
    run_op("pass_b", 4'b0110, 32'h55, 32'h99, 1, 32'h99, 1'b0);
    run_op("op_reset", 4'b1001, 32'h55, 32'h99, 1, 32'd0, 1'b1);
  endtask

  task automatic test_undefined();
    run_op("preload", 4'b0001, 32'd1, 32'd1, 1, 32'd2, 1'b0);
    run_op("undef_1011", 4'b1011, 32'd0, 32'd0, 1, 32'd2, 1'b0);
`ifdef ALU_DIV_EN
    run_op("div_100_7", 4'b1010, 32'd100, 32'd7, 33, 32'd14, 1'b0);
    run_op("div_by_0", 4'b1010, 32'd100, 32'd0, 33, 32'hFFFF_FFFF, 1'b0);
`else
    run_op("undef_1010", 4'b1010, 32'd0, 32'd0, 1, 32'd2, 1'b0);
`endif
  endtask

  task automatic test_rst_mid_op();
    int dones;
    issue(4'b0011, 32'd1234, 32'd5678);
    for (int i = 0; i < 9; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    tests_run++;
    if (busy !== 1'b0 || C_bus !== 32'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst mid-op: got busy=%b C=%h done=%b expected 0/0/0", busy, C_bus, done);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL rst mid-op stray done: got %0d expected 0", dones);
    end
    rst = 1; Control = 4'b0001; A_bus = 32'd1; B_bus = 32'd2; enable = 1;
    tick();
    rst = 0; enable = 0;
    tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || C_bus !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst+enable: got busy=%b done=%b C=%h expected 0/0/0", busy, done, C_bus);
    end
  endtask

  task automatic test_enable_while_busy();
    int lat, dones;
    issue(4'b0011, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    Control = 4'b0001; A_bus = 32'd100; B_bus = 32'd100; enable = 1;
    tick();
    enable = 0;
    wait_done(lat);
    tests_run++;
    if (lat + 6 !== 33 || C_bus !== 32'd12) begin
      tests_failed++;
      $display("FAIL busy-ignore: got lat=%0d C=%h expected lat=33 C=%h", lat + 6, C_bus, 32'd12);
    end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0 || C_bus !== 32'd12) begin
      tests_failed++;
      $display("FAIL busy-ignore extra: got dones=%0d C=%h expected 0 and %h", dones, C_bus, 32'd12);
    end
  endtask

  initial begin
    test_reset();
    test_add_back_to_back();
    test_mul();
    test_mod();
    test_wrap_pass();
    test_undefined();
    test_rst_mid_op();
    test_enable_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
